// File: rtl/online_mult_sequencer_if.sv
// Chunk-pair input stream for the online multiplier sequencer.
// The producer is master; the sequencer is slave.
interface online_mult_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x_plus_in;
    logic [3:0] x_minus_in;
    logic [3:0] y_plus_in;
    logic [3:0] y_minus_in;

    modport master (
        output in_valid,
        output x_plus_in,
        output x_minus_in,
        output y_plus_in,
        output y_minus_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  x_plus_in,
        input  x_minus_in,
        input  y_plus_in,
        input  y_minus_in,
        output in_ready
    );
endinterface

// File: rtl/online_mult_sequencer.sv
// Operand FIFO and init/compute/LSD/output sequencer for the adder control stage.
// Optional sticky underrun flag: define ONLINE_SEQ_UNDERRUN_FLAG_EN.
module online_mult_sequencer #(
    parameter int CHUNKS     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              p_in,
    online_mult_sequencer_if.slave  in_if,
    output logic [1:0]              STATE,
    output logic [6:0]              comp_cycle,
    output logic [8:0]              cnt_master,
    output logic [1:0]              p,
    output logic [3:0]              x_plus,
    output logic [3:0]              x_minus,
    output logic [3:0]              y_plus,
    output logic [3:0]              y_minus,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] LAST = 7'(CHUNKS - 1);
    localparam logic [6:0] NCH  = 7'(CHUNKS);
    localparam logic [7:0] ACC_MAX = 8'(CHUNKS);

    typedef enum logic [2:0] {
        IDLE, INIT, COMPUTE, LSD, OUTPUT, DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    accepted;
    logic          push, pop, pop_req, fifo_empty, start_ok;
    logic [6:0]    cc_d;
    logic [15:0]   dig_d;

    assign fifo_empty = (count == '0);
    assign in_if.in_ready = (count != CW'(FIFO_DEPTH))
                         && (accepted < ACC_MAX);
    assign push = in_if.in_valid && in_if.in_ready;
    assign pop = pop_req && !fifo_empty;
    assign start_ok = (state_q == IDLE) && start;
    // An empty FIFO during compute feeds zero digits instead of stalling.
    assign dig_d = pop ? mem[rd_ptr] : '0;

    always_comb begin
        state_d = state_q;
        cc_d = comp_cycle;
        pop_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    cc_d = '0;
                end
            end
            INIT: begin
                cc_d = 7'd1;
                if (comp_cycle == 7'd1
                    && (count >= CW'(2) || accepted == ACC_MAX)) begin
                    state_d = COMPUTE;
                    cc_d = '0;
                    pop_req = 1'b1;
                end
            end
            COMPUTE: begin
                if (comp_cycle == LAST) begin
                    state_d = LSD;
                    cc_d = NCH;
                end else begin
                    cc_d = comp_cycle + 7'd1;
                    pop_req = 1'b1;
                end
            end
            LSD: begin
                state_d = OUTPUT;
                cc_d = '0;
            end
            OUTPUT: begin
                if (comp_cycle == LAST) begin
                    state_d = DONE;
                    cc_d = '0;
                end else begin
                    cc_d = comp_cycle + 7'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cc_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            COMPUTE: STATE = 2'b01;
            LSD:     STATE = 2'b10;
            OUTPUT:  STATE = 2'b11;
            default: STATE = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            comp_cycle <= '0;
            cnt_master <= '0;
            p <= '0;
            {x_plus, x_minus, y_plus, y_minus} <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state_q <= state_d;
            comp_cycle <= cc_d;
            {x_plus, x_minus, y_plus, y_minus} <= dig_d;
            done <= (state_d == DONE);
            if (start_ok) begin
                p <= p_in;
                busy <= 1'b1;
                cnt_master <= '0;
            end else begin
                if (busy && cnt_master != 9'h1FF)
                    cnt_master <= cnt_master + 9'd1;
                if (state_q == DONE)
                    busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            accepted <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (state_q == DONE)
                accepted <= {7'd0, push};
            else if (push)
                accepted <= accepted + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_if.x_plus_in, in_if.x_minus_in,
                            in_if.y_plus_in, in_if.y_minus_in};
    end

`ifdef ONLINE_SEQ_UNDERRUN_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underrun <= 1'b0;
        else if (start_ok)
            underrun <= 1'b0;
        else if (pop_req && fifo_empty)
            underrun <= 1'b1;
    end
`else
    assign underrun = 1'b0;
`endif
endmodule

// File: tb/tb_online_mult_sequencer.sv
// Scoreboard bench for online_mult_sequencer: chunks queued on transfer,
// compared against the digits shown in each compute cycle.
module tb_online_mult_sequencer;
    localparam int CHUNKS = 8;
    localparam int DEPTH  = 4;
`ifdef ONLINE_SEQ_UNDERRUN_FLAG_EN
    localparam logic UF_EXP = 1'b1;
`else
    localparam logic UF_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] p_in = 2'b00;
    logic [1:0] STATE;
    logic [6:0] comp_cycle;
    logic [8:0] cnt_master;
    logic [1:0] p;
    logic [3:0] x_plus, x_minus, y_plus, y_minus;
    logic       busy, done, underrun;

    online_mult_sequencer_if ifc();

    online_mult_sequencer #(
        .CHUNKS(CHUNKS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .p_in(p_in),
        .in_if(ifc),
        .STATE(STATE),
        .comp_cycle(comp_cycle),
        .cnt_master(cnt_master),
        .p(p),
        .x_plus(x_plus),
        .x_minus(x_minus),
        .y_plus(y_plus),
        .y_minus(y_minus),
        .busy(busy),
        .done(done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic        pend = 1'b0;
    logic [15:0] pend_d = '0;
    int          acc_total = 0;
    bit          feed_on = 1'b0;
    int          feed_max = 0;
    int          send_cnt = 0;
    bit          ok;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare first, then enqueue the transfer seen last cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            if (STATE == 2'b01) begin
                if (exp_q.size() > 0)
                    check("sb_xy", {x_plus, x_minus, y_plus, y_minus},
                          exp_q.pop_front());
                else
                    check("sb_zero", {x_plus, x_minus, y_plus, y_minus}, 0);
            end
            if (pend) begin
                exp_q.push_back(pend_d);
                acc_total++;
            end
            pend = ifc.in_valid && ifc.in_ready;
            pend_d = {ifc.x_plus_in, ifc.x_minus_in,
                      ifc.y_plus_in, ifc.y_minus_in};
        end
    end

    initial begin
        logic f;
        ifc.in_valid = 1'b0;
        {ifc.x_plus_in, ifc.x_minus_in, ifc.y_plus_in, ifc.y_minus_in} = '0;
        forever begin
            @(negedge clk);
            f = ifc.in_valid && ifc.in_ready && !rst;
            @(posedge clk);
            #2;
            if (f)
                send_cnt++;
            if (f || !ifc.in_valid) begin
                ifc.x_plus_in  = 4'($urandom_range(15, 1));
                ifc.x_minus_in = 4'($urandom_range(15, 1));
                ifc.y_plus_in  = 4'($urandom_range(15, 1));
                ifc.y_minus_in = 4'($urandom_range(15, 1));
            end
            ifc.in_valid = feed_on && (send_cnt < feed_max);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [1:0] pv);
        step();
        start = 1'b1;
        p_in = pv;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        // Reset values
        repeat (2) samp();
        check("rst_state", STATE, 0);
        check("rst_cc", comp_cycle, 0);
        check("rst_cnt", cnt_master, 0);
        check("rst_p", p, 0);
        check("rst_xy", {x_plus, x_minus, y_plus, y_minus}, 0);
        check("rst_flags", {busy, done, underrun}, 0);
        check("rst_ready", ifc.in_ready, 1);
        step();
        rst = 1'b0;

        // Prefill and backpressure in IDLE
        send_cnt = 0;
        feed_max = 1000;
        feed_on = 1'b1;
        repeat (10) step();
        samp();
        check("bp_ready", ifc.in_ready, 0);
        check("bp_acc4", acc_total, 4);

        // Prefilled run with an ignored start during OUTPUT
        do_start(2'b01);
        samp();
        check("init0_state", STATE, 0);
        check("init0_cc", comp_cycle, 0);
        check("init0_busy", busy, 1);
        check("p_latch", p, 1);
        check("init0_cnt", cnt_master, 0);
        step();
        samp();
        check("init1_state", STATE, 0);
        check("init1_cc", comp_cycle, 1);
        for (int k = 0; k < CHUNKS; k++) begin
            step();
            samp();
            check("cmp_state", STATE, 1);
            check("cmp_cc", comp_cycle, k);
        end
        step();
        samp();
        check("lsd_state", STATE, 2);
        check("lsd_cc", comp_cycle, CHUNKS);
        check("lsd_xy", {x_plus, x_minus, y_plus, y_minus}, 0);
        check("lsd_ready", ifc.in_ready, 0);
        check("acc8", acc_total, 8);
        for (int k = 0; k < CHUNKS; k++) begin
            step();
            if (k == 0)
                feed_on = 1'b0;
            if (k == 2) begin
                start = 1'b1;
                p_in = 2'b10;
            end
            if (k == 3)
                start = 1'b0;
            samp();
            check("out_state", STATE, 3);
            check("out_cc", comp_cycle, k);
            check("out_xy", {x_plus, x_minus, y_plus, y_minus}, 0);
            check("out_ready", ifc.in_ready, 0);
        end
        step();
        samp();
        check("done_pulse", done, 1);
        check("done_state", STATE, 0);
        check("done_cnt", cnt_master, 19);
        check("p_kept", p, 1);
        check("pre_uf", underrun, 0);
        step();
        samp();
        check("done_low", done, 0);
        check("busy_low", busy, 0);
        check("acc_total8", acc_total, 8);
        check("sb_drain1", exp_q.size(), 0);

        // Late input: INIT holds until two chunks are buffered
        send_cnt = 0;
        feed_max = 8;
        do_start(2'b11);
        samp();
        check("late_cc0", comp_cycle, 0);
        check("late_p", p, 3);
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 5)
                feed_on = 1'b1;
            samp();
            check("late_state", STATE, 0);
            check("late_cc", comp_cycle, 1);
        end
        step();
        samp();
        check("late_go", STATE, 1);
        check("late_go_cc", comp_cycle, 0);
        wait_done(40, ok);
        check("late_cnt", cnt_master, 25);
        check("late_uf", underrun, 0);
        feed_on = 1'b0;
        step();
        samp();
        check("sb_drain2", exp_q.size(), 0);

        // Underrun: only four chunks ever arrive
        send_cnt = 0;
        feed_max = 4;
        feed_on = 1'b1;
        repeat (8) step();
        do_start(2'b10);
        wait_done(40, ok);
        check("uf_flag", underrun, UF_EXP);
        step();
        samp();
        check("uf_sticky", underrun, UF_EXP);
        feed_on = 1'b0;

        // Reset in the middle of COMPUTE
        send_cnt = 0;
        feed_max = 1000;
        feed_on = 1'b1;
        do_start(2'b00);
        samp();
        check("uf_clear", underrun, 0);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (STATE == 2'b01 && comp_cycle == 7'd3) begin
                ok = 1'b1;
                break;
            end
            samp();
        end
        check("reach_cc3", ok, 1);
        #2;
        rst = 1'b1;
        feed_on = 1'b0;
        #1;
        check("arst_state", STATE, 0);
        check("arst_cc", comp_cycle, 0);
        check("arst_cnt", cnt_master, 0);
        check("arst_xy", {x_plus, x_minus, y_plus, y_minus}, 0);
        check("arst_flags", {busy, done, underrun}, 0);
        check("arst_p", p, 0);
        check("arst_ready", ifc.in_ready, 1);
        repeat (2) step();
        rst = 1'b0;
        do_start(2'b01);
        samp();
        check("rerun_cc0", comp_cycle, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            samp();
            check("rerun_hold_state", STATE, 0);
            check("rerun_hold_cc", comp_cycle, 1);
        end
        send_cnt = 0;
        feed_max = 8;
        feed_on = 1'b1;
        wait_done(40, ok);
        check("rerun_uf", underrun, 0);
        check("rerun_p", p, 1);
        feed_on = 1'b0;
        step();
        samp();
        check("sb_drain3", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/online_mult_sequencer.md
# online_mult_sequencer

Operand sequencer and control source for the online multiplier's adder control logic stage. Buffers incoming redundant signed-digit operand chunks (4-bit plus/minus pairs for x and y) in a small FIFO. Drives the stage's `STATE`, `comp_cycle`, `cnt_master`, `p` and x/y digit inputs through a fixed init → compute → LSD read → output sequence, one sequence per `start`. Sits directly upstream of the adder control logic; all of its outputs connect 1:1 to that stage's inputs.

## Interface
- `CHUNKS`, 8 — operand chunks (4 digits each) per operation; legal range 1..127.
- `FIFO_DEPTH`, 4 — input buffer entries; a power of two, at least 2.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — begin an operation; sampled only in IDLE.
- `p_in`  in  2  — precision select, latched on an accepted `start`.
- `in_valid`  in  1  — chunk pair valid.
- `in_ready`  out  1  — sequencer can accept a chunk pair.
- `x_plus_in`, `x_minus_in`, `y_plus_in`, `y_minus_in`  in  4 each  — chunk pair.
- `STATE`  out  2  — 00 init/idle, 01 compute, 10 LSD read, 11 output.
- `comp_cycle`  out  7  — cycle index within the current phase.
- `cnt_master`  out  9  — cycles since `start`; saturates at 511.
- `p`  out  2  — latched precision.
- `x_plus`, `x_minus`, `y_plus`, `y_minus`  out  4 each  — digits to the adder.
- `busy`  out  1  — high from an accepted `start` until DONE exits.
- `done`  out  1  — one-cycle pulse in DONE.
- `underrun`  out  1  — sticky FIFO-empty-during-compute flag (see Configuration).

## Operation
- FSM states: IDLE, INIT, COMPUTE, LSD, OUTPUT, DONE.
- `STATE` encoding:
  - IDLE, INIT, DONE → 00
  - COMPUTE → 01
  - LSD → 10
  - OUTPUT → 11
- Input handshake:
  - A transfer occurs when `in_valid & in_ready` on a rising edge.
  - `in_ready = !fifo_full && (accepted < CHUNKS)`. This is valid in every state, so prefill during IDLE is allowed.
  - `accepted` clears on DONE exit.
- IDLE → INIT on `start`. On that edge: latch `p_in`; clear `cnt_master`, `comp_cycle` and `underrun`.
- INIT:
  - Minimum 2 cycles, with `comp_cycle` counting 0, 1, and holding 1 afterwards.
  - Exits to COMPUTE when both hold: `comp_cycle == 1` and (`fifo_count >= 2` or `accepted == CHUNKS`).
  - x/y outputs are forced to 0.
- COMPUTE:
  - Exactly `CHUNKS` cycles, `comp_cycle` 0..CHUNKS-1.
  - Each cycle pops the FIFO head onto the x/y outputs.
  - If the FIFO is empty, outputs are 0, there is no pop, and `underrun` sets.
  - After `comp_cycle == CHUNKS-1` → LSD.
- LSD: 1 cycle; `comp_cycle = CHUNKS`; x/y = 0.
- OUTPUT: `CHUNKS` cycles, `comp_cycle` 0..CHUNKS-1; x/y = 0 (flush). Then → DONE.
- DONE: 1 cycle; `done` = 1; → IDLE.
- `start` outside IDLE is ignored.
- Simultaneous push and pop with the FIFO full: the pop frees the slot, but `in_ready` is computed from the registered count, so no push occurs that cycle.
- Pointer wrap: modulo `FIFO_DEPTH`.
- `cnt_master`: +1 every cycle while `busy`; holds at 511; holds its value in IDLE.

## Timing
- All outputs are registered except `in_ready`, which is combinational from registered state.
- `STATE`, `comp_cycle` and the x/y digits change on the same edge. In the cycle where `STATE = 01` and `comp_cycle = k`, x/y carry chunk k.
- Total busy cycles with a prefilled FIFO: 2 + CHUNKS + 1 + CHUNKS + 1.
- Reset values:
  - FSM = IDLE; `STATE` = 00; `comp_cycle` = 0; `cnt_master` = 0; `p` = 00.
  - All x/y outputs = 0; `busy` = 0; `done` = 0; `underrun` = 0.
  - FIFO empty; `accepted` = 0.
- Reset mid-operation: immediate return to reset values, and buffered chunks are discarded.

## Configuration
- `ONLINE_SEQ_UNDERRUN_FLAG_EN`
  - Defined: `underrun` is implemented as described.
  - Undefined: `underrun` is tied to 0 and no flag logic is built. Zero-digit substitution on an empty FIFO still occurs.

## Test plan
- **Prefilled run** (CHUNKS=8): push 4 chunks in IDLE, pulse `start`, keep feeding → INIT 2 cycles, COMPUTE `comp_cycle` 0..7 with the pushed chunks in order, LSD `comp_cycle` = 8, OUTPUT 0..7, `done` pulse at `cnt_master` = 19; `underrun` = 0.
- **Late input**: `start` with the FIFO empty, first push 5 cycles later → INIT holds `STATE` = 00 with `comp_cycle` = 1 until `fifo_count` ≥ 2, then COMPUTE.
- **Underrun**: stop `in_valid` after chunk 3 during COMPUTE → `x_plus`/`y_plus` = 0 for `comp_cycle` 4..7, `underrun` = 1 sticky until the next `start`; with the macro undefined, `underrun` stays 0.
- **Backpressure**: hold `in_valid` = 1 with no `start` → `in_ready` drops after 4 pushes (FIFO full); after `start`, exactly 8 chunks are accepted in total, then `in_ready` = 0 until DONE.
- **Reset mid-COMPUTE**: assert `rst` at `comp_cycle` = 3 → all outputs go to reset values asynchronously; after release, a new `start` reruns from INIT with an empty FIFO.
- **Ignored start**: pulse `start` during OUTPUT with `p_in` = 10 → sequence unaffected, `p` keeps its original latched value.
